// File: rtl/inst_encoder_loader.sv
// Instruction loader: encodes symbolic requests into MIPS words, writes them
// to consecutive instruction-memory addresses from 0, and keeps the CPU held
// until the program has been fully written.
module inst_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Memory capacity in words (2**ADDR_W), expressed in the count width.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              err_reg, err_next;
  logic              done_reg, done_next;
  logic              hold_reg;
  logic              ready_reg, ready_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       enc_word;
  logic              op_legal;
  logic              fire;

  assign req_ready  = ready_reg;
  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign cpu_hold   = hold_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign count      = count_reg;

  // ready is a register, so the transfer condition never loops back through req_valid.
  assign fire = req_valid && ready_reg;

  // Encode the request; fields an op does not use are dropped (shamt always 0).
  always_comb begin
    enc_word = 32'd0;
    op_legal = 1'b1;
    case (req_op)
      3'd0:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h20};
      3'd1:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h2A};
      3'd2:    enc_word = {6'h23, req_rs, req_rt, req_imm};
      3'd3:    enc_word = {6'h2B, req_rs, req_rt, req_imm};
      3'd4:    enc_word = {6'h08, req_rs, req_rt, req_imm};
      3'd5:    enc_word = {6'h04, req_rs, req_rt, req_imm};
      default: op_legal = 1'b0;
    endcase
  end

  // Session sequencing: start opens a session, last or a full memory closes it.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    err_next   = err_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_LOAD;
          count_next = '0;
          err_next   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (fire) begin
          if (op_legal) begin
            we_next    = 1'b1;
            addr_next  = count_reg[ADDR_W-1:0];
            wdata_next = enc_word;
            count_next = count_reg + ONE;
            if (req_last) begin
              state_next = ST_DONE;
            end else if (count_next == DEPTH) begin
              state_next = ST_DONE;
              err_next   = 1'b1;
            end
          end else begin
            err_next = 1'b1;
            if (req_last) begin
              state_next = ST_DONE;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    ready_next = (state_next == ST_LOAD) && (count_next < DEPTH);
    // done trails entry to DONE by one cycle so the last write lands before the CPU runs.
    done_next  = (state_reg == ST_DONE) && (state_next == ST_DONE);
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
      hold_reg  <= 1'b1;
      ready_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
      hold_reg  <= !done_next;
      ready_reg <= ready_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

endmodule
